// File: rtl/spi_pkg.sv
// spi_pkg: state encoding and small helpers shared by spi_master and spi_clk_gen.
package spi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  function automatic int spi_len_w(input int size);
    return $clog2(size + 1);
  endfunction

  // A length of zero or beyond the word size means a full-width transfer.
  function automatic int spi_clamp_len(input int len, input int size);
    if ((len == 0) || (len > size)) return size;
    return len;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period down-counter, SCLK edge ticks and the registered SCLK itself.
module spi_clk_gen #(
  parameter int CLK_SIZE = 3
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  input  logic                cpol_in,
  input  logic [CLK_SIZE-1:0] hmax_in,
  input  logic                run_in,
  output logic                tick_out,
  output logic                lead_out,
  output logic                trail_out,
  output logic                clk_out
);

  logic [CLK_SIZE-1:0] cnt_q, cnt_d;
  logic [CLK_SIZE-1:0] hmax_q, hmax_d;
  logic                cpol_q, cpol_d;
  logic                sclk_q, sclk_d;
  logic                toggle;

  always_comb begin
    tick_out  = (cnt_q == '0);
    toggle    = tick_out && run_in;
    lead_out  = toggle && (sclk_q == cpol_q);
    trail_out = toggle && (sclk_q != cpol_q);

    cnt_d  = cnt_q;
    hmax_d = hmax_q;
    cpol_d = cpol_q;
    sclk_d = sclk_q;

    if (start_in) begin
      cnt_d  = hmax_in;
      hmax_d = hmax_in;
      cpol_d = cpol_in;
      sclk_d = cpol_in;
    end else begin
      cnt_d = tick_out ? hmax_q : (cnt_q - CLK_SIZE'(1));
      if (toggle) sclk_d = ~sclk_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q  <= '0;
      hmax_q <= '0;
      cpol_q <= 1'b0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hmax_q <= hmax_d;
      cpol_q <= cpol_d;
      sclk_q <= sclk_d;
    end
  end

  assign clk_out = sclk_q;

endmodule

// File: rtl/spi_master.sv
// spi_master: start/busy/done SPI master with runtime mode, length, CS mask and divider.
// Optional SPI_LSB_FIRST_EN adds lsb_first_in for LSB-first framing.
//
// state | meaning
// IDLE  | waiting for start_in, CS high, SCLK parked at last CPOL
// SETUP | CS asserted, SCLK at CPOL for H cycles
// SHIFT | 2*N half periods of SCLK, data moves on the edges
// HOLD  | SCLK back at CPOL, CS still asserted for H cycles
// GAP   | CS released for H cycles before done
module spi_master
  import spi_pkg::*;
#(
  parameter int SIZE     = 40,
  parameter int CS_SIZE  = 1,
  parameter int CLK_SIZE = 3,
  localparam int LEN_W   = spi_len_w(SIZE)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  input  logic [SIZE-1:0]     data_in,
  input  logic [LEN_W-1:0]    len_in,
  input  logic                cpol_in,
  input  logic                cpha_in,
  input  logic [CS_SIZE-1:0]  cs_select_in,
  input  logic [CLK_SIZE-1:0] clk_count_max,
`ifdef SPI_LSB_FIRST_EN
  input  logic                lsb_first_in,
`endif
  input  logic                serial_in,
  output logic [SIZE-1:0]     data_out,
  output logic                busy_out,
  output logic                done_out,
  output logic                clk_out,
  output logic                serial_out,
  output logic [CS_SIZE-1:0]  r_cs_out
);

  localparam int SEG_W = LEN_W + 1;

  logic [2:0]         state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CS_SIZE-1:0] cs_q, cs_d;
  logic [SIZE-1:0]    data_q, data_d;
  logic               mosi_q, mosi_d;
  logic [SIZE-1:0]    tx_q, tx_d;
  logic [SIZE-1:0]    rx_q, rx_d;
  logic [LEN_W-1:0]   n_q, n_d;
  logic               cpha_q, cpha_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
`ifdef SPI_LSB_FIRST_EN
  logic               lsb_q, lsb_d;
`endif

  logic [LEN_W-1:0] n_acc;
  logic [SIZE-1:0]  tx_load;
  logic             gen_start;
  logic             run;
  logic             tick, lead, trail;
  logic             sample_ev, drive_ev;

  // seg_q counts the SHIFT half periods still to come after the current one.
  assign run = (state_q == ST_SETUP) || ((state_q == ST_SHIFT) && (seg_q != '0));

  spi_clk_gen #(
    .CLK_SIZE (CLK_SIZE)
  ) u_clk_gen (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start_in  (gen_start),
    .cpol_in   (cpol_in),
    .hmax_in   (clk_count_max),
    .run_in    (run),
    .tick_out  (tick),
    .lead_out  (lead),
    .trail_out (trail),
    .clk_out   (clk_out)
  );

  // The transmit word is left-aligned so the first wire bit always sits at the MSB.
  always_comb begin
    n_acc   = LEN_W'(spi_clamp_len(int'(len_in), SIZE));
    tx_load = data_in << (SIZE - int'(n_acc));
`ifdef SPI_LSB_FIRST_EN
    if (lsb_first_in) begin
      for (int i = 0; i < SIZE; i++) tx_load[SIZE-1-i] = data_in[i];
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cs_d      = cs_q;
    data_d    = data_q;
    mosi_d    = mosi_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    n_d       = n_q;
    cpha_d    = cpha_q;
    seg_d     = seg_q;
`ifdef SPI_LSB_FIRST_EN
    lsb_d     = lsb_q;
`endif
    gen_start = 1'b0;

    // With CPHA=0 the last trailing edge has no further bit to launch.
    sample_ev = cpha_q ? trail : lead;
    drive_ev  = cpha_q ? lead : (trail && (seg_q != SEG_W'(1)));

    if (drive_ev) begin
      mosi_d = tx_q[SIZE-1];
      tx_d   = tx_q << 1;
    end
    if (sample_ev) begin
`ifdef SPI_LSB_FIRST_EN
      if (lsb_q) begin
        rx_d = rx_q >> 1;
        rx_d[n_q - LEN_W'(1)] = serial_in;
      end else begin
        rx_d = {rx_q[SIZE-2:0], serial_in};
      end
`else
      rx_d = {rx_q[SIZE-2:0], serial_in};
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d   = ST_SETUP;
          busy_d    = 1'b1;
          cs_d      = ~cs_select_in;
          n_d       = n_acc;
          cpha_d    = cpha_in;
          seg_d     = {n_acc, 1'b0} - SEG_W'(1);
          rx_d      = '0;
          gen_start = 1'b1;
`ifdef SPI_LSB_FIRST_EN
          lsb_d     = lsb_first_in;
`endif
          if (!cpha_in) begin
            mosi_d = tx_load[SIZE-1];
            tx_d   = tx_load << 1;
          end else begin
            tx_d   = tx_load;
          end
        end
      end
      ST_SETUP: begin
        if (tick) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick) begin
          if (seg_q == '0) state_d = ST_HOLD;
          else             seg_d   = seg_q - SEG_W'(1);
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_GAP;
          cs_d    = '1;
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          data_d  = rx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cs_d    = '1;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= '1;
      data_q  <= '0;
      mosi_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      n_q     <= '0;
      cpha_q  <= 1'b0;
      seg_q   <= '0;
`ifdef SPI_LSB_FIRST_EN
      lsb_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      data_q  <= data_d;
      mosi_q  <= mosi_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      n_q     <= n_d;
      cpha_q  <= cpha_d;
      seg_q   <= seg_d;
`ifdef SPI_LSB_FIRST_EN
      lsb_q   <= lsb_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign busy_out   = busy_q;
  assign done_out   = done_q;
  assign serial_out = mosi_q;
  assign r_cs_out   = cs_q;

endmodule
